// File: rtl/rgb_to_ddr_writer_if.sv
// Bundle of the FIFO read-side and Spartan-6 MCB write-port signals used by
// rgb_to_ddr_writer. The master modport is the writer; the slave modport is
// the environment (async FIFO read side plus MCB port).
//
// Handshake semantics:
//   fifo_read_enable is a read strobe. Each high cycle pops one word, and that
//   word appears on fifo_data_out in the following cycle. The master only reads
//   when fifo_rd_data_count already covers a whole burst.
//   mcb_wr_en pushes one mcb_wr_data/mcb_wr_mask word into the MCB write FIFO.
//   Space is checked once, before a burst starts, so writes are never refused.
//   mcb_cmd_en is the valid strobe and !mcb_cmd_full is the ready. A command is
//   transferred in a cycle where both are true, and mcb_cmd_en is only raised
//   in such cycles.
interface rgb_to_ddr_writer_if #(
  parameter int RGB_WIDTH        = 24,
  parameter int DATA_COUNT_WIDTH = 13,
  parameter int ADDR_WIDTH       = 30
);
  logic [RGB_WIDTH-1:0]        fifo_data_out;
  logic [DATA_COUNT_WIDTH-1:0] fifo_rd_data_count;
  logic                        fifo_empty;
  logic                        fifo_read_enable;

  logic                        mcb_cmd_en;
  logic [2:0]                  mcb_cmd_instr;
  logic [5:0]                  mcb_cmd_bl;
  logic [ADDR_WIDTH-1:0]       mcb_cmd_byte_addr;
  logic                        mcb_cmd_full;

  logic                        mcb_wr_en;
  logic [31:0]                 mcb_wr_data;
  logic [3:0]                  mcb_wr_mask;
  logic                        mcb_wr_full;
  logic [6:0]                  mcb_wr_count;
  logic                        mcb_wr_underrun;
  logic                        mcb_wr_error;

  modport master (
    input  fifo_data_out, fifo_rd_data_count, fifo_empty,
    output fifo_read_enable,
    output mcb_cmd_en, mcb_cmd_instr, mcb_cmd_bl, mcb_cmd_byte_addr,
    input  mcb_cmd_full,
    output mcb_wr_en, mcb_wr_data, mcb_wr_mask,
    input  mcb_wr_full, mcb_wr_count, mcb_wr_underrun, mcb_wr_error
  );

  modport slave (
    output fifo_data_out, fifo_rd_data_count, fifo_empty,
    input  fifo_read_enable,
    input  mcb_cmd_en, mcb_cmd_instr, mcb_cmd_bl, mcb_cmd_byte_addr,
    output mcb_cmd_full,
    input  mcb_wr_en, mcb_wr_data, mcb_wr_mask,
    output mcb_wr_full, mcb_wr_count, mcb_wr_underrun, mcb_wr_error
  );
endinterface

// File: rtl/rgb_to_ddr_writer.sv
// Drains 24-bit pixels from the pixel-to-DDR async FIFO (DDR clock domain) and
// writes them to DDR through one MCB write port in fixed-length bursts. Each
// pixel becomes {8'h00, rgb}. Burst addresses walk linearly through one frame
// buffer and wrap to its base after the last burst of a frame.
module rgb_to_ddr_writer #(
  parameter int RGB_WIDTH        = 24,
  parameter int DATA_COUNT_WIDTH = 13,
  parameter int BURST_LEN        = 32,
  parameter int ADDR_WIDTH       = 30,
  parameter int FRAME_BASE       = 0,
  parameter int FRAME_WORDS      = 786432
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  rgb_to_ddr_writer_if.master        bus,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       error,
  output logic [1:0]                 dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2,
    S_CMD   = 2'd3
  } state_t;

  localparam int WC_W = $clog2(FRAME_WORDS + 1);

  localparam logic [5:0]            LAST_RD   = 6'(BURST_LEN - 1);
  localparam logic [WC_W-1:0]       WORD_STEP = WC_W'(BURST_LEN);
  localparam logic [WC_W-1:0]       LAST_CNT  = WC_W'(FRAME_WORDS - BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(4 * BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] ADDR_BASE = ADDR_WIDTH'(FRAME_BASE);
  localparam logic [DATA_COUNT_WIDTH-1:0] MIN_LEVEL = DATA_COUNT_WIDTH'(BURST_LEN);
  localparam logic [6:0]            MAX_WR_COUNT = 7'(64 - BURST_LEN);

  state_t                  state;
  logic [5:0]              rd_cnt;
  logic                    drain_cnt;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [WC_W-1:0]         word_cnt;
  logic                    rd_d1;

  logic start_ok;
  logic cmd_fire;
  logic last_burst;

  // A burst may start only when a whole burst is buffered upstream and the
  // MCB write FIFO has room for all of it, so nothing is monitored mid-burst.
  assign start_ok = enable
                 && (bus.fifo_rd_data_count >= MIN_LEVEL)
                 && !bus.mcb_wr_full
                 && (bus.mcb_wr_count <= MAX_WR_COUNT);

  // The command goes out in the first CMD cycle where the command FIFO has room.
  assign cmd_fire   = (state == S_CMD) && !bus.mcb_cmd_full;
  assign last_burst = (word_cnt == LAST_CNT);

  assign bus.mcb_cmd_en        = cmd_fire;
  assign bus.mcb_cmd_instr     = 3'b000;
  assign bus.mcb_cmd_bl        = 6'(BURST_LEN - 1);
  assign bus.mcb_cmd_byte_addr = addr;
  assign bus.mcb_wr_mask       = 4'b0000;

  assign frame_done = cmd_fire && last_burst;
  assign busy       = (state != S_IDLE);
  assign dbg_state  = state;

  // Burst sequencer: read BURST_LEN pixels, let the write pipe empty, then command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= S_IDLE;
      bus.fifo_read_enable <= 1'b0;
      rd_cnt               <= '0;
      drain_cnt            <= 1'b0;
      addr                 <= ADDR_BASE;
      word_cnt             <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            state                <= S_FILL;
            bus.fifo_read_enable <= 1'b1;
            rd_cnt               <= '0;
          end
        end
        S_FILL: begin
          if (rd_cnt == LAST_RD) begin
            bus.fifo_read_enable <= 1'b0;
            drain_cnt            <= 1'b0;
            state                <= S_DRAIN;
          end else begin
            rd_cnt <= rd_cnt + 6'd1;
          end
        end
        S_DRAIN: begin
          // Two cycles cover the two data-path stages behind the last read.
          if (drain_cnt) begin
            state <= S_CMD;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        S_CMD: begin
          if (cmd_fire) begin
            state <= S_IDLE;
            if (last_burst) begin
              addr     <= ADDR_BASE;
              word_cnt <= '0;
            end else begin
              addr     <= addr + ADDR_STEP;
              word_cnt <= word_cnt + WORD_STEP;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Two-stage write path: FIFO data is valid the cycle after the read strobe
  // and is registered into the MCB write port one cycle after that.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_d1           <= 1'b0;
      bus.mcb_wr_en   <= 1'b0;
      bus.mcb_wr_data <= '0;
    end else begin
      rd_d1         <= bus.fifo_read_enable;
      bus.mcb_wr_en <= rd_d1;
      if (rd_d1) begin
        bus.mcb_wr_data <= {{(32 - RGB_WIDTH){1'b0}}, bus.fifo_data_out};
      end
    end
  end

  // Sticky error: MCB underrun/error, or a read strobe while the FIFO is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error <= 1'b0;
    end else if (bus.mcb_wr_underrun || bus.mcb_wr_error
                 || (bus.fifo_empty && bus.fifo_read_enable)) begin
      error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rgb_to_ddr_writer.sv
// Directed bench for rgb_to_ddr_writer with BURST_LEN=4, FRAME_WORDS=8,
// FRAME_BASE=0x100. A small array models the pixel FIFO; expected write words,
// command addresses and frame_done values are queued by the stimulus.
module tb_rgb_to_ddr_writer;

  localparam int BL   = 4;
  localparam int FW   = 8;
  localparam int BASE = 'h100;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       busy;
  logic       frame_done;
  logic       error;
  logic [1:0] dbg_state;

  rgb_to_ddr_writer_if #(.RGB_WIDTH(24), .DATA_COUNT_WIDTH(13), .ADDR_WIDTH(30)) ifc ();

  rgb_to_ddr_writer #(
    .RGB_WIDTH(24), .DATA_COUNT_WIDTH(13), .BURST_LEN(BL),
    .ADDR_WIDTH(30), .FRAME_BASE(BASE), .FRAME_WORDS(FW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bus(ifc),
    .busy(busy), .frame_done(frame_done), .error(error), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [29:0] exp_addr_q[$];
  logic        exp_fd_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- FIFO model ----------------
  logic [23:0] mem [0:63];
  int wp = 0;
  int rp;

  assign ifc.fifo_rd_data_count = 13'(wp - rp);
  assign ifc.fifo_empty         = (wp == rp);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rp <= 0;
    end else if (ifc.fifo_read_enable) begin
      ifc.fifo_data_out <= mem[rp % 64];
      rp <= rp + 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_pixel(input logic [23:0] p);
    mem[wp % 64] = p;
    wp = wp + 1;
    exp_q.push_back({8'h00, p});
  endtask

  task automatic expect_cmd(input logic [29:0] a, input logic fd);
    exp_addr_q.push_back(a);
    exp_fd_q.push_back(fd);
  endtask

  task automatic apply_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    wp     = 0;
    exp_q.delete();
    exp_addr_q.delete();
    exp_fd_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    bit done = 1'b0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      @(negedge clk);
      if (exp_addr_q.size() == 0 && !busy) done = 1'b1;
    end
    chk(tag, 64'(done), 64'd1);
  endtask

  // ---------------- monitor ----------------
  logic rd_h1, rd_h2;
  int   wr_since;
  int   rd_total = 0;

  always @(negedge clk) begin
    logic [31:0] exp_w;
    logic [29:0] exp_a;
    logic        exp_f;
    if (!rst_n) begin
      rd_h1    = 1'b0;
      rd_h2    = 1'b0;
      wr_since = 0;
    end else begin
      chk("wr_en_latency", 64'(ifc.mcb_wr_en), 64'(rd_h2));
      rd_h2 = rd_h1;
      rd_h1 = ifc.fifo_read_enable;
      if (ifc.fifo_read_enable) rd_total++;
      if (ifc.mcb_wr_en) begin
        wr_since++;
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        chk("wr_data", 64'(ifc.mcb_wr_data), 64'(exp_w));
      end
      if (ifc.mcb_cmd_en) begin
        chk("writes_before_cmd", 64'(wr_since), 64'(BL));
        wr_since = 0;
        exp_a = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 'x;
        exp_f = (exp_fd_q.size() > 0) ? exp_fd_q.pop_front() : 'x;
        chk("cmd_addr", 64'(ifc.mcb_cmd_byte_addr), 64'(exp_a));
        chk("cmd_frame_done", 64'(frame_done), 64'(exp_f));
        chk("cmd_bl", 64'(ifc.mcb_cmd_bl), 64'd3);
        chk("cmd_instr", 64'(ifc.mcb_cmd_instr), 64'd0);
      end else begin
        chk("frame_done_no_cmd", 64'(frame_done), 64'd0);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  logic [7:0] rd_tr, wr_tr, cmd_tr, busy_tr;
  int         rd_before;
  bit         found;

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    ifc.fifo_data_out   = '0;
    ifc.mcb_cmd_full    = 1'b0;
    ifc.mcb_wr_full     = 1'b0;
    ifc.mcb_wr_count    = 7'd0;
    ifc.mcb_wr_underrun = 1'b0;
    ifc.mcb_wr_error    = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_rd_en", 64'(ifc.fifo_read_enable), 64'd0);
    chk("rst_cmd_en", 64'(ifc.mcb_cmd_en), 64'd0);
    chk("rst_wr_en", 64'(ifc.mcb_wr_en), 64'd0);
    chk("rst_wr_data", 64'(ifc.mcb_wr_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    chk("rst_addr", 64'(ifc.mcb_cmd_byte_addr), 64'h100);
    chk("rst_bl", 64'(ifc.mcb_cmd_bl), 64'd3);
    chk("rst_instr", 64'(ifc.mcb_cmd_instr), 64'd0);
    chk("rst_mask", 64'(ifc.mcb_wr_mask), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single burst: exact cycle pattern of reads, writes and command
    for (int i = 1; i <= 4; i++) push_pixel(24'(i));
    expect_cmd(30'h100, 1'b0);
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rd_tr[i]   = ifc.fifo_read_enable;
      wr_tr[i]   = ifc.mcb_wr_en;
      cmd_tr[i]  = ifc.mcb_cmd_en;
      busy_tr[i] = busy;
    end
    chk("burst1_rd_trace", 64'(rd_tr), 64'h0F);
    chk("burst1_wr_trace", 64'(wr_tr), 64'h3C);
    chk("burst1_cmd_trace", 64'(cmd_tr), 64'h40);
    chk("burst1_busy_trace", 64'(busy_tr), 64'h7F);
    enable = 1'b0;

    // Three bursts across a frame boundary
    apply_reset();
    for (int i = 0; i < 12; i++) push_pixel((i == 5) ? 24'hFFFFFF : {8'(i), 8'hA5, 8'(255 - i)});
    expect_cmd(30'h100, 1'b0);
    expect_cmd(30'h110, 1'b1);
    expect_cmd(30'h100, 1'b0);
    enable = 1'b1;
    wait_idle("frame_wrap_done", 100);
    chk("frame_wrap_fifo_drained", 64'(ifc.fifo_rd_data_count), 64'd0);
    enable = 1'b0;

    // Level threshold: 3 words must not start a burst, 4 must
    apply_reset();
    for (int i = 0; i < 3; i++) push_pixel(24'h300000 + 24'(i));
    enable = 1'b1;
    rd_before = rd_total;
    repeat (6) @(negedge clk);
    chk("level3_no_reads", 64'(rd_total - rd_before), 64'd0);
    chk("level3_idle", 64'(busy), 64'd0);
    expect_cmd(30'h100, 1'b0);
    push_pixel(24'h300003);
    @(negedge clk);
    chk("level4_starts", 64'(ifc.fifo_read_enable), 64'd1);
    wait_idle("level4_done", 40);

    // Command FIFO full stalls CMD for 10 cycles
    ifc.mcb_cmd_full = 1'b1;
    for (int i = 0; i < 4; i++) push_pixel(24'h400000 + 24'(i));
    expect_cmd(30'h110, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (dbg_state == 2'd3) found = 1'b1;
    end
    chk("stall_reached_cmd", 64'(found), 64'd1);
    for (int i = 0; i < 10; i++) begin
      chk("stall_cmd_en_low", 64'(ifc.mcb_cmd_en), 64'd0);
      chk("stall_addr_stable", 64'(ifc.mcb_cmd_byte_addr), 64'h110);
      if (i < 9) @(negedge clk);
    end
    @(posedge clk);
    #1 ifc.mcb_cmd_full = 1'b0;
    @(negedge clk);
    chk("stall_release_cmd", 64'(ifc.mcb_cmd_en), 64'd1);
    chk("stall_release_fd", 64'(frame_done), 64'd1);
    @(negedge clk);
    chk("stall_cmd_once", 64'(ifc.mcb_cmd_en), 64'd0);
    chk("stall_back_idle", 64'(busy), 64'd0);
    enable = 1'b0;

    // MCB write FIFO occupancy gate; the next address shows a single advance
    ifc.mcb_wr_count = 7'd61;
    for (int i = 0; i < 4; i++) push_pixel(24'h500000 + 24'(i));
    enable = 1'b1;
    rd_before = rd_total;
    repeat (6) @(negedge clk);
    chk("wrcount61_no_reads", 64'(rd_total - rd_before), 64'd0);
    expect_cmd(30'h100, 1'b0);
    ifc.mcb_wr_count = 7'd60;
    @(negedge clk);
    chk("wrcount60_starts", 64'(ifc.fifo_read_enable), 64'd1);
    wait_idle("wrcount60_done", 40);
    enable = 1'b0;
    ifc.mcb_wr_count = 7'd0;

    // Sticky error from mcb_wr_error
    chk("error_clear_before", 64'(error), 64'd0);
    ifc.mcb_wr_error = 1'b1;
    @(negedge clk);
    ifc.mcb_wr_error = 1'b0;
    chk("error_set_wr_error", 64'(error), 64'd1);
    repeat (5) @(negedge clk);
    chk("error_sticky", 64'(error), 64'd1);
    apply_reset();
    chk("error_cleared_by_reset", 64'(error), 64'd0);

    // Sticky error from mcb_wr_underrun
    ifc.mcb_wr_underrun = 1'b1;
    @(negedge clk);
    ifc.mcb_wr_underrun = 1'b0;
    chk("error_set_underrun", 64'(error), 64'd1);

    // Reset during FILL aborts the burst at once
    apply_reset();
    for (int i = 0; i < 4; i++) push_pixel(24'h600000 + 24'(i));
    enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("midfill_wr_active", 64'(ifc.mcb_wr_en), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midfill_rst_rd_en", 64'(ifc.fifo_read_enable), 64'd0);
    chk("midfill_rst_wr_en", 64'(ifc.mcb_wr_en), 64'd0);
    chk("midfill_rst_cmd_en", 64'(ifc.mcb_cmd_en), 64'd0);
    chk("midfill_rst_busy", 64'(busy), 64'd0);
    apply_reset();
    for (int i = 0; i < 4; i++) push_pixel(24'h700000 + 24'(i));
    expect_cmd(30'h100, 1'b0);
    enable = 1'b1;
    wait_idle("after_abort_done", 40);
    enable = 1'b0;

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("cmd_queue_empty", 64'(exp_addr_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
